half_adder: RTL and testbench

HALF_ADDER -- requirements
Module: half_adder

---
 rtl/half_adder_pkg.sv | 19 +
 rtl/half_adder.sv | 73 +++++++
 tb/tb_half_adder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/half_adder_pkg.sv
// Half-adder lane types and the single-lane reference function.
//   ha_bit_t  : {carry, sum} result of one lane
//   ha_lane() : combinational half-add of two bits
package half_adder_pkg;

    typedef struct packed {
        logic carry;
        logic sum;
    } ha_bit_t;

    // One 1-bit half-adder lane
    function automatic ha_bit_t ha_lane(input logic a, input logic b);
        ha_bit_t r;
        r.sum   = a ^ b;
        r.carry = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes behind a one-deep valid/ready pipeline
// register, with a saturating count of accepted operand pairs.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   input1, input2      per-lane addends          (WIDTH)
//   in_valid, in_ready  input handshake; in_ready is combinational
//   sum, carry          registered per-lane result (WIDTH)
//   out_valid, out_ready output handshake
//   op_count            accepted-pair count, saturates at all-ones (CNT_W)
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;
    logic             in_xfer_c;
    logic             out_xfer_c;

    // Per-lane combinational half adders; lanes never interact
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_bit_t r_c;
        assign r_c        = ha_lane(input1[i], input2[i]);
        assign sum_c[i]   = r_c.sum;
        assign carry_c[i] = r_c.carry;
    end

    // A full output register can only take new data in the cycle it drains
    assign in_ready   = ~out_valid | out_ready;
    assign in_xfer_c  = in_valid & in_ready;
    assign out_xfer_c = out_valid & out_ready;

    // Result register: load on input transfer, otherwise drop valid on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carry     <= '0;
            out_valid <= 1'b0;
        end else if (in_xfer_c) begin
            sum       <= sum_c;
            carry     <= carry_c;
            out_valid <= 1'b1;
        end else if (out_xfer_c) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating accepted-pair counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (in_xfer_c && (op_count != CNT_MAX)) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: three instances (WIDTH=1, WIDTH=8 with
// a 2-bit counter, WIDTH=16) sharing clock and reset.
module tb_half_adder;

    logic clk;
    logic rst_n;

    // WIDTH=1, CNT_W=16
    logic        a1, b1, v1, ordy1, s1, c1, ov1, ir1;
    logic [15:0] cnt1;
    // WIDTH=8, CNT_W=2
    logic [7:0]  a8, b8, s8, c8;
    logic        v8, ordy8, ov8, ir8;
    logic [1:0]  cnt8;
    // WIDTH=16, CNT_W=16
    logic [15:0] a16, b16, s16, c16;
    logic        v16, ordy16, ov16, ir16;
    logic [15:0] cnt16;

    int vectors     = 0;
    int miscompares = 0;

    half_adder #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .input1(a1), .input2(b1), .in_valid(v1),
        .in_ready(ir1), .sum(s1), .carry(c1), .out_valid(ov1),
        .out_ready(ordy1), .op_count(cnt1));

    half_adder #(.WIDTH(8), .CNT_W(2)) u_w8 (
        .clk(clk), .rst_n(rst_n), .input1(a8), .input2(b8), .in_valid(v8),
        .in_ready(ir8), .sum(s8), .carry(c8), .out_valid(ov8),
        .out_ready(ordy8), .op_count(cnt8));

    half_adder #(.WIDTH(16), .CNT_W(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .input1(a16), .input2(b16), .in_valid(v16),
        .in_ready(ir16), .sum(s16), .carry(c16), .out_valid(ov16),
        .out_ready(ordy16), .op_count(cnt16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each lane is a 1-bit addition; result packed {carry, sum}
    function automatic logic [31:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic [15:0] c;
        int t;
        for (int i = 0; i < 16; i++) begin
            t    = int'(a[i]) + int'(b[i]);
            s[i] = t[0];
            c[i] = t[1];
        end
        return {c, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({ov1, s1, c1, cnt1, ir1} !== {3'b000, 16'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_w1: got %h expected %h", {ov1, s1, c1, cnt1, ir1}, {3'b000, 16'd0, 1'b1});
        end
        vectors++;
        if ({ov8, s8, c8, cnt8, ir8} !== {1'b0, 16'd0, 2'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_w8: got %h expected %h", {ov8, s8, c8, cnt8, ir8}, {1'b0, 16'd0, 2'd0, 1'b1});
        end
        vectors++;
        if ({ov16, s16, c16, cnt16, ir16} !== {1'b0, 48'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_w16: got %h expected %h", {ov16, s16, c16, cnt16, ir16}, {1'b0, 48'd0, 1'b1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_truth_table();
        logic [31:0] e;
        logic [1:0]  idx;
        ordy1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i);
            a1  = idx[0];
            b1  = idx[1];
            v1  = 1'b1;
            tick();
            e = ref_add({15'd0, a1}, {15'd0, b1});
            vectors++;
            if ({ov1, s1, c1} !== {1'b1, e[0], e[16]}) begin
                miscompares++;
                $display("FAIL truth_%0d%0d: got ov,s,c=%b expected %b", a1, b1, {ov1, s1, c1}, {1'b1, e[0], e[16]});
            end
        end
        v1 = 1'b0;
        vectors++;
        if (cnt1 !== 16'd4) begin
            miscompares++;
            $display("FAIL truth_count: got %0d expected 4", cnt1);
        end
        tick();
        vectors++;
        if ({ov1, s1, c1} !== 3'b001) begin
            miscompares++;
            $display("FAIL drain_hold: got ov,s,c=%b expected 001", {ov1, s1, c1});
        end
    endtask

    task automatic test_wide_pattern();
        ordy8 = 1'b1;
        a8 = 8'hF0;
        b8 = 8'hAA;
        v8 = 1'b1;
        tick();
        v8 = 1'b0;
        vectors++;
        if ({ov8, s8, c8} !== {1'b1, 8'h5A, 8'hA0}) begin
            miscompares++;
            $display("FAIL wide_f0_aa: got ov=%b s=%h c=%h expected 1 5a a0", ov8, s8, c8);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        ordy8 = 1'b0;
        a8 = 8'h3C;
        b8 = 8'h0F;
        v8 = 1'b1;
        tick();
        e  = ref_add({8'd0, a8}, {8'd0, b8});
        a8 = 8'hFF;
        b8 = 8'h81;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({ir8, ov8, s8, c8} !== {1'b0, 1'b1, e[7:0], e[23:16]}) begin
                miscompares++;
                $display("FAIL stall_%0d: got rdy=%b ov=%b s=%h c=%h expected 0 1 %h %h",
                         k, ir8, ov8, s8, c8, e[7:0], e[23:16]);
            end
            tick();
        end
        ordy8 = 1'b1;
        #1;
        vectors++;
        if (ir8 !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready: got %b expected 1", ir8);
        end
        tick();
        e  = ref_add({8'd0, a8}, {8'd0, b8});
        v8 = 1'b0;
        vectors++;
        if ({ov8, s8, c8} !== {1'b1, e[7:0], e[23:16]}) begin
            miscompares++;
            $display("FAIL replace: got ov=%b s=%h c=%h expected 1 %h %h", ov8, s8, c8, e[7:0], e[23:16]);
        end
        tick();
        vectors++;
        if (ov8 !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_w8: got ov=%b expected 0", ov8);
        end
    endtask

    task automatic test_async_reset();
        ordy1 = 1'b0;
        a1 = 1'b1;
        b1 = 1'b1;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        vectors++;
        if (ov1 !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_valid: got %b expected 1", ov1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ov1, s1, c1, cnt1, ir1} !== {3'b000, 16'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset_w1: got %h expected %h", {ov1, s1, c1, cnt1, ir1}, {3'b000, 16'd0, 1'b1});
        end
        vectors++;
        if (cnt8 !== 2'd0) begin
            miscompares++;
            $display("FAIL async_reset_cnt8: got %0d expected 0", cnt8);
        end
        a1 = 1'b1;
        b1 = 1'b0;
        v1 = 1'b1;
        tick();
        vectors++;
        if ({ov1, cnt1} !== 17'd0) begin
            miscompares++;
            $display("FAIL no_xfer_in_reset: got ov=%b cnt=%0d expected 0 0", ov1, cnt1);
        end
        #3;
        rst_n = 1'b1;
        ordy1 = 1'b1;
        tick();
        v1 = 1'b0;
        vectors++;
        if ({ov1, s1, c1, cnt1} !== {3'b110, 16'd1}) begin
            miscompares++;
            $display("FAIL post_reset_first: got ov,s,c=%b cnt=%0d expected 110 1", {ov1, s1, c1}, cnt1);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] e;
        int          exp_cnt;
        ordy8 = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            v8 = 1'b1;
            tick();
            e       = ref_add({8'd0, a8}, {8'd0, b8});
            exp_cnt = (n < 3) ? n : 3;
            vectors++;
            if ({cnt8, s8, c8} !== {2'(exp_cnt), e[7:0], e[23:16]}) begin
                miscompares++;
                $display("FAIL sat_%0d: got cnt=%0d s=%h c=%h expected %0d %h %h",
                         n, cnt8, s8, c8, exp_cnt, e[7:0], e[23:16]);
            end
        end
        v8 = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] e;
        logic        exp_ready;
        int          pushed = 0;
        int          popped = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            vectors++;
            if (ov16 !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL rnd_valid_%0d: got %b expected %b", cyc, ov16, q.size() != 0);
            end
            v16    = 1'($urandom_range(0, 1));
            ordy16 = ($urandom_range(0, 3) != 0);
            a16    = 16'($urandom);
            b16    = 16'($urandom);
            #1;
            exp_ready = (q.size() == 0) || ordy16;
            vectors++;
            if (ir16 !== exp_ready) begin
                miscompares++;
                $display("FAIL rnd_ready_%0d: got %b expected %b", cyc, ir16, exp_ready);
            end
            if (q.size() != 0 && ordy16) begin
                e = q.pop_front();
                popped++;
                vectors++;
                if ({c16, s16} !== e) begin
                    miscompares++;
                    $display("FAIL rnd_result_%0d: got c=%h s=%h expected %h %h", cyc, c16, s16, e[31:16], e[15:0]);
                end
            end
            if (v16 && exp_ready) begin
                q.push_back(ref_add(a16, b16));
                pushed++;
            end
            tick();
        end
        v16 = 1'b0;
        vectors++;
        if (cnt16 !== 16'(pushed) || pushed != popped + q.size()) begin
            miscompares++;
            $display("FAIL rnd_count: got cnt=%0d expected %0d (popped %0d, pending %0d)",
                     cnt16, pushed, popped, q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {a1, b1, v1, ordy1} = '0;
        {a8, b8, v8, ordy8} = '0;
        {a16, b16, v16, ordy16} = '0;
        test_reset();
        test_truth_table();
        test_wide_pattern();
        test_backpressure();
        test_async_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
